// File: rtl/soundrive_sd_dac.sv
`default_nettype none
// ============================================================================
// Module   : soundrive_sd_dac
// Purpose  : Soundrive/Covox audio back end. It resamples four 8-bit unsigned
//            channel registers at a fixed rate, mixes them into one 9-bit sum
//            per side, and drives a first-order sigma-delta bitstream per side
//            to the RC-filtered audio pins.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SAMPLE_DIV  clk28 cycles per sample latch (>= 2; 256 gives ~109 kHz)
// Ports
//   clk28       in   1  system clock
//   rst         in   1  synchronous reset, active-high, has priority over en
//   en          in   1  block enable; 0 = idle, bitstreams driven low
//   mute        in   1  latch midscale instead of the mix at the next sample
//   ch_l0/ch_l1 in   8  left channels, unsigned, 0x80 = silence
//   ch_r0/ch_r1 in   8  right channels, unsigned, 0x80 = silence
//   sample_stb  out  1  one-cycle pulse after a new sample is latched
//   sum_l/sum_r out  9  latched per-side mix
//   out_l/out_r out  1  per-side sigma-delta bitstream
// Build option
//   SOUNDRIVE_DAC_DITHER_EN  when defined, a 16-bit LFSR supplies a carry-in
//                            to each modulator to break up idle tones.
// ============================================================================
module soundrive_sd_dac #(
  parameter int SAMPLE_DIV = 256
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       en,
  input  logic       mute,
  input  logic [7:0] ch_l0,
  input  logic [7:0] ch_l1,
  input  logic [7:0] ch_r0,
  input  logic [7:0] ch_r1,
  output logic       sample_stb,
  output logic [8:0] sum_l,
  output logic [8:0] sum_r,
  output logic       out_l,
  output logic       out_r
);

  localparam int              CNT_W    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [8:0]       MIDSCALE = 9'h100;

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             stb_q;
  logic [8:0]       sum_l_q, sum_r_q;
  logic [8:0]       sum_l_d, sum_r_d;
  logic [8:0]       acc_l_q, acc_r_q;
  logic             out_l_q, out_r_q;
  logic             wrap;
  logic [9:0]       t_l, t_r;
  logic             cin_l, cin_r;

`ifdef SOUNDRIVE_DAC_DITHER_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Right-shifting Fibonacci form of taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign cin_l   = lfsr_q[0];
  assign cin_r   = lfsr_q[1];

  always_ff @(posedge clk28) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (en) begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end
`else
  assign cin_l = 1'b0;
  assign cin_r = 1'b0;
`endif

  always_comb begin
    wrap      = (div_cnt_q == CNT_LAST);
    div_cnt_d = wrap ? '0 : div_cnt_q + CNT_W'(1);
    sum_l_d   = mute ? MIDSCALE : ({1'b0, ch_l0} + {1'b0, ch_l1});
    sum_r_d   = mute ? MIDSCALE : ({1'b0, ch_r0} + {1'b0, ch_r1});
    // The modulator adds the sum registered before this edge, so a freshly
    // latched sample reaches the bitstream one cycle after the strobe.
    t_l       = {1'b0, acc_l_q} + {1'b0, sum_l_q} + {9'd0, cin_l};
    t_r       = {1'b0, acc_r_q} + {1'b0, sum_r_q} + {9'd0, cin_r};
  end

  always_ff @(posedge clk28) begin
    if (rst) begin
      div_cnt_q <= '0;
      stb_q     <= 1'b0;
      sum_l_q   <= MIDSCALE;
      sum_r_q   <= MIDSCALE;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      out_l_q   <= 1'b0;
      out_r_q   <= 1'b0;
    end else if (!en) begin
      // Idle: restart the prescaler and accumulators, keep the last sample.
      div_cnt_q <= '0;
      stb_q     <= 1'b0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      out_l_q   <= 1'b0;
      out_r_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      stb_q     <= wrap;
      if (wrap) begin
        sum_l_q <= sum_l_d;
        sum_r_q <= sum_r_d;
      end
      acc_l_q   <= t_l[8:0];
      acc_r_q   <= t_r[8:0];
      out_l_q   <= t_l[9];
      out_r_q   <= t_r[9];
    end
  end

  assign sample_stb = stb_q;
  assign sum_l      = sum_l_q;
  assign sum_r      = sum_r_q;
  assign out_l      = out_l_q;
  assign out_r      = out_r_q;

endmodule
`default_nettype wire

// File: tb/tb_soundrive_sd_dac.sv
`default_nettype none
// ============================================================================
// Module   : tb_soundrive_sd_dac
// Purpose  : Directed bench for soundrive_sd_dac with SAMPLE_DIV = 8 and the
//            dither option not built. Expected values are worked out by hand
//            from the sigma-delta recurrence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soundrive_sd_dac;

  localparam int SD = 8;

  logic       clk28 = 1'b0;
  logic       rst, en, mute;
  logic [7:0] ch_l0, ch_l1, ch_r0, ch_r1;
  logic       sample_stb, out_l, out_r;
  logic [8:0] sum_l, sum_r;

  int vectors    = 0;
  int miscompares = 0;

  soundrive_sd_dac #(.SAMPLE_DIV(SD)) dut (
    .clk28      (clk28),
    .rst        (rst),
    .en         (en),
    .mute       (mute),
    .ch_l0      (ch_l0),
    .ch_l1      (ch_l1),
    .ch_r0      (ch_r0),
    .ch_r1      (ch_r1),
    .sample_stb (sample_stb),
    .sum_l      (sum_l),
    .sum_r      (sum_r),
    .out_l      (out_l),
    .out_r      (out_r)
  );

  always #5 clk28 = ~clk28;

  // Advance one clock and sample 1 ns after the edge.
  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Step until a strobe is seen, bounded; the final check flags a timeout.
  task automatic wait_stb(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_stb && n < 4 * SD);
    chk(tag, {15'd0, sample_stb}, 16'd1);
  endtask

  initial begin : stim
    logic [15:0] pat_l, pat_r;
    int          stb_cnt, ones_l, ones_r, drift;

    rst = 1'b1; en = 1'b1; mute = 1'b0;
    ch_l0 = 8'h80; ch_l1 = 8'h80; ch_r0 = 8'h80; ch_r1 = 8'h80;

    // ---- reset held for three edges with en=1 ----
    repeat (3) step();
    chk("rst_stb",   {15'd0, sample_stb}, 16'd0);
    chk("rst_sum_l", {7'd0, sum_l},       16'h0100);
    chk("rst_sum_r", {7'd0, sum_r},       16'h0100);
    chk("rst_out_l", {15'd0, out_l},      16'd0);
    chk("rst_out_r", {15'd0, out_r},      16'd0);

    // ---- release: strobe on edge SD, silence alternates 0,1 from acc=0 ----
    rst = 1'b0;
    stb_cnt = 0; pat_l = '0; pat_r = '0;
    for (int k = 1; k <= 16; k++) begin
      step();
      pat_l[k-1] = out_l;
      pat_r[k-1] = out_r;
      if (k == SD || k == 2 * SD)
        chk($sformatf("stb_at_%0d", k), {15'd0, sample_stb}, 16'd1);
      else if (sample_stb)
        stb_cnt++;
    end
    chk("stb_spurious", 16'(stb_cnt), 16'd0);
    chk("silence_l",    pat_l,        16'hAAAA);
    chk("silence_r",    pat_r,        16'hAAAA);
    chk("silence_sum_l", {7'd0, sum_l}, 16'h0100);

    // ---- full scale: 510 ones left, none right over 512 cycles ----
    ch_l0 = 8'hFF; ch_l1 = 8'hFF; ch_r0 = 8'h00; ch_r1 = 8'h00;
    wait_stb("fs_stb");
    chk("fs_sum_l", {7'd0, sum_l}, 16'd510);
    chk("fs_sum_r", {7'd0, sum_r}, 16'd0);
    ones_l = 0; ones_r = 0;
    for (int k = 0; k < 512; k++) begin
      step();
      ones_l += int'(out_l);
      ones_r += int'(out_r);
    end
    chk("fs_ones_l", 16'(ones_l), 16'd510);
    chk("fs_ones_r", 16'(ones_r), 16'd0);

    // ---- hold between strobes, then mute ----
    ch_l0 = 8'h80; ch_l1 = 8'h80; ch_r0 = 8'h80; ch_r1 = 8'h80;
    wait_stb("hold_stb0");
    chk("hold_sum_l0", {7'd0, sum_l}, 16'h0100);
    step(); step();
    ch_l0 = 8'h10; ch_r0 = 8'h40;
    drift = 0;
    do begin
      step();
      if (!sample_stb && sum_l !== 9'h100) drift++;
    end while (!sample_stb && drift < 64 && vectors < 1000 && $time < 64'd200000);
    chk("hold_drift",   16'(drift), 16'd0);
    chk("hold_stb1",    {15'd0, sample_stb}, 16'd1);
    chk("hold_sum_l1",  {7'd0, sum_l}, 16'h0090);
    chk("hold_sum_r1",  {7'd0, sum_r}, 16'h00C0);
    mute = 1'b1;
    wait_stb("mute_stb");
    chk("mute_sum_l", {7'd0, sum_l}, 16'h0100);
    chk("mute_sum_r", {7'd0, sum_r}, 16'h0100);
    mute = 1'b0;
    wait_stb("unmute_stb");
    chk("unmute_sum_l", {7'd0, sum_l}, 16'h0090);

    // ---- enable gating ----
    step(); step(); step();
    en = 1'b0;
    step();
    chk("dis_out_l", {15'd0, out_l},      16'd0);
    chk("dis_out_r", {15'd0, out_r},      16'd0);
    chk("dis_stb",   {15'd0, sample_stb}, 16'd0);
    repeat (5) step();
    chk("dis_sum_l", {7'd0, sum_l}, 16'h0090);
    chk("dis_sum_r", {7'd0, sum_r}, 16'h00C0);
    // sum_l=144 from acc=0: carries on edges 4 and 8 -> 0x88.
    // sum_r=192 from acc=0: carries on edges 3, 6 and 8 -> 0xA4.
    en = 1'b1;
    stb_cnt = 0; pat_l = '0; pat_r = '0;
    for (int k = 1; k <= SD; k++) begin
      step();
      pat_l[k-1] = out_l;
      pat_r[k-1] = out_r;
      if (k < SD && sample_stb) stb_cnt++;
    end
    chk("en_early_stb", 16'(stb_cnt),          16'd0);
    chk("en_stb",       {15'd0, sample_stb},   16'd1);
    chk("en_pat_l",     pat_l,                 16'h0088);
    chk("en_pat_r",     pat_r,                 16'h00A4);

    // ---- reset mid-operation ----
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("mrst_sum_l", {7'd0, sum_l},       16'h0100);
    chk("mrst_sum_r", {7'd0, sum_r},       16'h0100);
    chk("mrst_stb",   {15'd0, sample_stb}, 16'd0);
    chk("mrst_out_r", {15'd0, out_r},      16'd0);
    rst = 1'b0;
    stb_cnt = 0;
    for (int k = 1; k < SD; k++) begin
      step();
      if (sample_stb) stb_cnt++;
    end
    chk("mrst_early_stb", 16'(stb_cnt), 16'd0);
    step();
    chk("mrst_stb_at_sd", {15'd0, sample_stb}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/soundrive_sd_dac.md
Name: soundrive_sd_dac

Overview:
Downstream stage of the Soundrive/Covox port-latch block. It consumes the four 8-bit unsigned channel registers (ch_l0, ch_l1, ch_r0, ch_r1; midscale 0x80).
- Resamples the channels at a fixed rate.
- Mixes them into per-side 9-bit sums.
- Drives one first-order sigma-delta bitstream per side to the board's RC-filtered audio pins.

Parameters:
SAMPLE_DIV, 256, clk28 cycles per sample latch (must be ≥2; 256 gives ~109 kHz)

Ports:
clk28  in  1  system clock, 28 MHz
rst  in  1  synchronous reset, active-high
en  in  1  block enable; 0 = idle, outputs low
mute  in  1  force midscale at next sample latch
ch_l0  in  8  left channel 0, unsigned, 0x80 = silence
ch_l1  in  8  left channel 1
ch_r0  in  8  right channel 0
ch_r1  in  8  right channel 1
sample_stb  out  1  one-cycle pulse when a new sample is latched
sum_l  out  9  latched left mix
sum_r  out  9  latched right mix
out_l  out  1  left sigma-delta bitstream
out_r  out  1  right sigma-delta bitstream

Behaviour:
- Reset: synchronous; all state updates only on posedge clk28; rst has priority over en.
- Reset values:
  - div_cnt=0, sample_stb=0
  - sum_l=sum_r=9'h100
  - acc_l=acc_r=0 (9-bit each)
  - out_l=out_r=0
  - LFSR=16'hACE1 (only when the optional feature is built)
- Prescaler:
  - While en=1, div_cnt counts 0..SAMPLE_DIV-1 and wraps to 0.
  - sample_stb is registered; it is 1 in the cycle after div_cnt==SAMPLE_DIV-1, so the strobe period is exactly SAMPLE_DIV cycles.
- Sample latch: on the edge where div_cnt==SAMPLE_DIV-1 (same edge that sets sample_stb):
  - sum_l <= {1'b0,ch_l0} + {1'b0,ch_l1} (range 0..510, no saturation needed)
  - sum_r <= {1'b0,ch_r0} + {1'b0,ch_r1}
  - If mute=1 on that edge, both sums latch 9'h100 instead.
  - Channel changes between strobes are not visible; sums hold.
- Modulator: each cycle with en=1, per side:
  - t = {1'b0,acc} + {1'b0,sum} + cin (10-bit)
  - acc <= t[8:0]; out <= t[9]; cin=0 unless the optional feature is built
  - Ones density over 512 cycles = sum/512 exactly (cin=0).
  - sum=0x100 gives alternating 0,1 starting 0 from acc=0.
  - The modulator uses the sum value registered before the edge, so a new sum affects out one cycle after sample_stb.
- en=0:
  - div_cnt, acc_l, acc_r cleared to 0; sample_stb=0; out_l=out_r=0.
  - sum_l and sum_r hold their values; LFSR holds.
- en 0→1: the first strobe occurs SAMPLE_DIV cycles after the first en=1 edge; the modulator resumes immediately using the held sums.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of div_cnt or pending strobe.

Optional Feature:
SOUNDRIVE_DAC_DITHER_EN
- Defined:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11, seeded 16'hACE1 on rst.
  - Shifts every en=1 cycle.
  - LFSR[0] is cin for the left side; LFSR[1] is cin for the right side.
  - This breaks idle tones; long-run density becomes (sum+0.5)/512.
- Undefined: cin=0, no LFSR registers; behaviour exactly as above.

Test Plan:
1. Reset check: assert rst 3 cycles with en=1 -> sample_stb=0, sum_l=sum_r=0x100, out_l=out_r=0; release rst -> sample_stb=1 exactly SAMPLE_DIV cycles after the first non-reset edge, then every SAMPLE_DIV cycles.
2. Silence: all ch=0x80, en=1, dither off -> after first strobe sum_l=sum_r=0x100; out_l/out_r alternate 0,1,0,1 (256 ones per 512 cycles).
3. Full scale: SAMPLE_DIV=4, ch_l0=ch_l1=0xFF, ch_r0=ch_r1=0x00 -> sum_l=510, sum_r=0; over 512 cycles out_l has 510 ones and out_r stays 0.
4. Hold between strobes: SAMPLE_DIV=8, change ch_l0 from 0x80 to 0x10 two cycles after a strobe -> sum_l unchanged until the next strobe, then sum_l=0x90; with mute=1 at that strobe -> sum_l=0x100.
5. Enable gating: deassert en mid-stream -> next cycle out_l=out_r=0, sample_stb=0, sums held; reassert -> first strobe after SAMPLE_DIV cycles and bitstream restarts from acc=0.
6. Dither build (SOUNDRIVE_DAC_DITHER_EN): ch=0x80 all, 65535 cycles -> LFSR sequence matches the reference model from 0xACE1; out_l ones count within ±1 of the model value.
